// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared FSM encoding and default sizing for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_AFULL_LVL  = 12;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/dual_port_ram.sv
// Dual-port RAM: synchronous write on port 0, asynchronous read on both ports.
module dual_port_ram #(
  parameter int data_width = 8,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  port_en_0,
  input  logic                  port_en_1,
  input  logic                  wr_en,
  input  logic [data_width-1:0] data_in,
  input  logic [addr_width-1:0] addr_in_0,
  input  logic [addr_width-1:0] addr_in_1,
  output logic [data_width-1:0] data_out_0,
  output logic [data_width-1:0] data_out_1
);

  logic [data_width-1:0] mem_q [2**addr_width];

  always_ff @(posedge clk) begin
    if (port_en_0 && wr_en) begin
      mem_q[addr_in_0] <= data_in;
    end
  end

  assign data_out_0 = port_en_0 ? mem_q[addr_in_0] : '0;
  assign data_out_1 = port_en_1 ? mem_q[addr_in_1] : '0;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller over a dual-port RAM, with
// EMPTY/ACTIVE/FULL state machine, almost-full flag and sticky overflow.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int addr_width = DEF_ADDR_WIDTH,
  parameter int depth      = DEF_DEPTH,
  parameter int afull_lvl  = DEF_AFULL_LVL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  input  logic [data_width-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [data_width-1:0] rd_data,
  input  logic                  rd_ready,
  output logic [addr_width:0]   count,
  output logic                  almost_full,
  output logic                  ovf_err
);

  localparam logic [addr_width:0] CNT_ONE  = (addr_width+1)'(1);
  localparam logic [addr_width:0] CNT_LAST = (addr_width+1)'(depth - 1);
  localparam logic [addr_width:0] CNT_AF   = (addr_width+1)'(afull_lvl);

  fifo_state_t           state_q, state_d;
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop;

  assign wr_ready    = (state_q != FULL);
  assign rd_valid    = (state_q != EMPTY);
  assign count       = count_q;
  assign almost_full = (count_q >= CNT_AF);
  assign ovf_err     = ovf_q;

  // Reset and flush suppress the RAM write as well as the bookkeeping.
  assign push = wr_valid && wr_ready && !flush && !rst;
  assign pop  = rd_valid && rd_ready && !flush && !rst;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (wr_valid && state_q == FULL) begin
      ovf_d = 1'b1;
    end

    if (flush) begin
      state_d  = EMPTY;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + addr_width'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + addr_width'(1);
      end
      count_d = count_q + (addr_width+1)'(push)
                        - (addr_width+1)'(pop);

      case (state_q)
        EMPTY: begin
          if (push) state_d = ACTIVE;
        end
        ACTIVE: begin
          if (push && !pop && count_q == CNT_LAST) begin
            state_d = FULL;
          end else if (pop && !push && count_q == CNT_ONE) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) state_d = ACTIVE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  dual_port_ram #(
    .data_width (data_width),
    .addr_width (addr_width)
  ) u_ram (
    .clk        (clk),
    .port_en_0  (push),
    .port_en_1  (1'b1),
    .wr_en      (push),
    .data_in    (wr_data),
    .addr_in_0  (wr_ptr_q),
    .addr_in_1  (rd_ptr_q),
    .data_out_0 (),
    .data_out_1 (rd_data)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a queue scoreboard of FIFO contents.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic [4:0] count;
  logic       almost_full;
  logic       ovf_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mq[$];
  logic       ovf_m;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(
    .data_width (8),
    .addr_width (4),
    .depth      (16),
    .afull_lvl  (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .count       (count),
    .almost_full (almost_full),
    .ovf_err     (ovf_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: check outputs against the model, drive
  // the next inputs, update the model, then advance to the next falling edge.
  task automatic cyc(input logic wv, input logic [7:0] wd,
                     input logic rr, input logic fl);
    int  sz;
    logic pushm, popm;
    sz = mq.size();
    chk("count", 32'(count), 32'(sz));
    chk("wr_ready", 32'(wr_ready), 32'(sz < 16));
    chk("rd_valid", 32'(rd_valid), 32'(sz > 0));
    chk("almost_full", 32'(almost_full), 32'(sz >= 12));
    chk("ovf_err", 32'(ovf_err), 32'(ovf_m));
    if (sz > 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    pushm = wv && (sz < 16);
    popm  = rr && (sz > 0);
    if (wv && sz == 16) ovf_m = 1'b1;
    if (fl) begin
      mq.delete();
    end else begin
      if (popm) void'(mq.pop_front());
      if (pushm) mq.push_back(wd);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic wv);
    rst      = 1'b1;
    wr_valid = wv;
    wr_data  = 8'hEE;
    rd_ready = 1'b1;
    flush    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    mq.delete();
    ovf_m = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0;
    wr_data = '0; rd_ready = 1'b0; ovf_m = 1'b0;
    repeat (2) @(negedge clk);
    do_reset(1'b0);

    // Fill to FULL with 0x01..0x10
    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Refused write in FULL, then write+pop in FULL also refuses the write
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Drain the rest
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // One-cycle write-to-read latency
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming at count=5 across pointer wrap
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);

    // Flush at count=7 overriding push and pop
    cyc(1'b1, 8'hC0, 1'b0, 1'b0);
    cyc(1'b1, 8'hC1, 1'b0, 1'b0);
    chk("count_pre_flush", 32'(count), 32'd7);
    cyc(1'b1, 8'hC2, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_after_flush", 32'(ovf_err), 32'd1);

    // Reset mid-operation at count=3
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    do_reset(1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Post-reset sanity: ordinary push/pop still works
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
